// File: rtl/operand_ctrl_pkg.sv
// operand_ctrl_pkg: opcodes, forwarding encodings and pipeline stage record
// shared by operand_hazard_ctrl and instr_class_decode.
package operand_ctrl_pkg;
    localparam int AW = 5;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef enum logic {DST_RD, DST_RT} dst_sel_t;
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dst;
        logic          regwrite;
        logic          memread;
        logic          uses_rs;
        logic          uses_rt;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          alu_src;
    } stage_t;
    // True when consumer reads a register that producer will write.
    function automatic logic src_hit(stage_t prod, stage_t cons);
        return prod.regwrite &&
               ((cons.uses_rs && prod.dst == cons.rs) || (cons.uses_rt && prod.dst == cons.rt));
    endfunction
    function automatic logic [1:0] fwd_sel(stage_t mem, stage_t wb, logic en, logic [AW-1:0] src);
        return !en ? FWD_REG :
               (mem.regwrite && mem.dst == src) ? FWD_MEM :
               (wb.regwrite && wb.dst == src) ? FWD_WB : FWD_REG;
    endfunction
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: maps an opcode to its operand/destination class.
module instr_class_decode
    import operand_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic                uses_rs,
    output logic                uses_rt,
    output dst_sel_t            dst_sel,
    output logic                alu_src,
    output logic                memread,
    output logic                regwrite
);
    logic is_r, is_imm, is_lw, is_sw, is_beq;
    assign is_r   = opcode == OPCODE_W'(OP_RTYPE);
    assign is_imm = opcode == OPCODE_W'(OP_ADDI) || opcode == OPCODE_W'(OP_SLTI);
    assign is_lw  = opcode == OPCODE_W'(OP_LW);
    assign is_sw  = opcode == OPCODE_W'(OP_SW);
    assign is_beq = opcode == OPCODE_W'(OP_BEQ);
    assign uses_rs  = is_r || is_imm || is_lw || is_sw || is_beq;
    assign uses_rt  = is_r || is_sw || is_beq;
    assign dst_sel  = is_r ? DST_RD : DST_RT;
    assign alu_src  = is_imm || is_lw || is_sw;
    assign memread  = is_lw;
    assign regwrite = is_r || is_imm || is_lw;
endmodule

// File: rtl/operand_hazard_ctrl.sv
// operand_hazard_ctrl: operand-B select, forwarding selects and hazard stall for EX.
// Define OPSEL_FORWARD_EN for forwarding; otherwise dependents stall until the producer reaches WB.
module operand_hazard_ctrl
    import operand_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 6,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [OPCODE_W-1:0]   id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  alu_src,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);
    stage_t ex, mem, wb, dec;
    logic d_rs, d_rt, d_as, d_mr, d_rw;
    dst_sel_t d_sel;

    instr_class_decode #(.OPCODE_W(OPCODE_W)) u_dec (
        .opcode   (id_opcode),
        .uses_rs  (d_rs),
        .uses_rt  (d_rt),
        .dst_sel  (d_sel),
        .alu_src  (d_as),
        .memread  (d_mr),
        .regwrite (d_rw)
    );

    always_comb begin
        dec          = '0;
        dec.valid    = d_rs;
        dec.dst      = d_sel == DST_RD ? AW'(id_rd) : AW'(id_rt);
        dec.regwrite = d_rw && dec.dst != '0;
        dec.memread  = d_mr;
        dec.uses_rs  = d_rs;
        dec.uses_rt  = d_rt;
        dec.rs       = AW'(id_rs);
        dec.rt       = AW'(id_rt);
        dec.alu_src  = d_as;
    end

    assign alu_src = ex.alu_src;

`ifdef OPSEL_FORWARD_EN
    assign stall = id_valid && !flush && ex.memread && src_hit(ex, dec);
    assign fwd_a = fwd_sel(mem, wb, ex.uses_rs, ex.rs);
    assign fwd_b = fwd_sel(mem, wb, ex.uses_rt, ex.rt);
`else
    // WB is written before read, so only EX and MEM producers block.
    assign stall = id_valid && !flush && (src_hit(ex, dec) || src_hit(mem, dec));
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex          <= '0;
            mem         <= '0;
            wb          <= '0;
            stall_count <= '0;
        end else begin
            wb  <= mem;
            mem <= ex;
            ex  <= (id_valid && !stall && !flush) ? dec : '0;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: doc/operand_hazard_ctrl.md
Name: operand_hazard_ctrl

Overview:
- Controller for the ALU operand-B select mux and the operand forwarding muxes in the pipelined datapath.
- Tracks the destination and write-enable of in-flight instructions in EX, MEM and WB.
- Drives the mux select (register vs sign-extended immediate) and the forwarding selects for the instruction in EX.
- Detects load-use hazards and stalls IF/ID while inserting bubbles into EX.

Parameters:
REG_ADDR_W, 5, register index width
OPCODE_W, 6, opcode field width
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_opcode  input  OPCODE_W  opcode of ID instruction
id_rs  input  REG_ADDR_W  rs field
id_rt  input  REG_ADDR_W  rt field
id_rd  input  REG_ADDR_W  rd field
flush  input  1  branch taken; discard ID instruction
alu_src  output  1  select to operand-B mux (1 = sign-extended immediate)
fwd_a  output  2  operand-A source: 00 regfile, 01 WB, 10 MEM
fwd_b  output  2  operand-B/store-data source, same encoding
stall  output  1  hold PC and IF/ID; bubble into EX
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Decode classes:
  - R-type 0x00: src rs,rt; dst rd; alu_src=0.
  - addi 0x08 / slti 0x0A: src rs; dst rt; alu_src=1.
  - lw 0x23: src rs; dst rt; alu_src=1; memread.
  - sw 0x2B: src rs,rt; no dst; alu_src=1.
  - beq 0x04: src rs,rt; no dst; alu_src=0.
  - Other opcodes: treated as bubble (no src, no dst, alu_src=0).
  - Dest index 0 forces regwrite=0.
- Internal stage registers EX, MEM, WB hold {valid, dst, regwrite, memread, uses_rs, uses_rt, rs, rt, alu_src}.
- Advance and latency:
  - Each cycle WB<=MEM and MEM<=EX.
  - EX<=decoded ID if id_valid && !stall && !flush; otherwise EX<=bubble.
  - An instruction accepted at cycle N is in EX at N+1, MEM at N+2, WB at N+3.
- alu_src, fwd_a, fwd_b:
  - Functions of stage registers only; no combinational path from id_*.
  - Valid for the instruction in EX.
- Forwarding priority, operand A (rs), only if EX.uses_rs:
  - MEM.regwrite && MEM.dst==EX.rs -> 10.
  - Else WB.regwrite && WB.dst==EX.rs -> 01.
  - Else 00.
  - fwd_b uses the same rules on rt, gated by EX.uses_rt.
  - Bubbles in EX produce 00/00/alu_src=0.
- Load-use stall, combinational:
  - stall = id_valid && !flush && EX.memread && EX.dst!=0 && ((uses_rs(id) && EX.dst==id_rs) || (uses_rt(id) && EX.dst==id_rt)).
  - Exactly one stall cycle per lw-use pair.
- Register file is write-before-read; WB never causes a stall.
- flush and stall together: flush wins, stall=0, bubble into EX.
- stall_count: +1 per cycle with stall=1; saturates at all-ones.
- Reset: all stage registers become bubbles; alu_src=0, fwd_a=fwd_b=00, stall=0, stall_count=0. Reset mid-stall drops the pending instruction; the upstream pipeline must re-fetch.

Optional Feature:
OPSEL_FORWARD_EN
- Defined: forwarding as above.
- Undefined:
  - fwd_a=fwd_b=00 always.
  - stall asserts whenever an ID source matches a regwrite dst in EX or MEM, lw or not.
  - Dependent instructions stall 1-2 cycles until the producer reaches WB.
  - stall_count counts these cycles identically.

Decomposition:
- Package operand_ctrl_pkg holds:
  - opcode constants.
  - fwd select encodings FWD_REG/FWD_WB/FWD_MEM.
  - stage-record struct typedef.
- One sub-module, instr_class_decode, maps opcode to {uses_rs, uses_rt, dst_sel, alu_src, memread, regwrite}.

Test Plan:
- addi r1,r0,5 then add r2,r1,r1 back-to-back -> add in EX sees fwd_a=10, fwd_b=10, alu_src=0, stall never asserts.
- lw r3,0(r0) then add r4,r3,r0 -> stall=1 for exactly one cycle, stall_count=1, add in EX two cycles after the lw with fwd_a=01.
- add r0,r1,r2 then add r5,r0,r0 -> regwrite suppressed, fwd_a=fwd_b=00.
- lw r6 then beq r6,r7 with flush=1 in the same cycle -> stall=0, EX bubble, stall_count unchanged.
- Without OPSEL_FORWARD_EN: addi r1 then sub r2,r1,r1 -> stall=1 for two cycles, fwd always 00, stall_count=2.
- rst asserted during an active stall -> next cycle all outputs 0, stall_count=0; saturation checked by forcing CNT_W=4 and 20 stalls -> stall_count=15.
